// File: rtl/mod_reduce_64.sv
// Sequential modular reducer: remainder of a P_WIDTH-bit product by an M_WIDTH-bit
// modulus, computed by radix-2 restoring shift-subtract, one product bit per clock.
module mod_reduce_64 #(
  parameter int P_WIDTH = 64,
  parameter int M_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [P_WIDTH-1:0] input_tdata,
  input  logic [M_WIDTH-1:0] modulus_tdata,
  input  logic               input_tvalid,
  output logic               input_tready,
  output logic [M_WIDTH-1:0] output_tdata,
  output logic               output_tuser,
  output logic               output_tvalid,
  input  logic               output_tready
);

  localparam int CNT_W = $clog2(P_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(P_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [P_WIDTH-1:0] p_r, p_s;
  logic [M_WIDTH-1:0] m_r, m_s;
  logic [M_WIDTH:0]   r_r, r_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [M_WIDTH-1:0] data_r, data_s;
  logic               user_r, user_s;
  logic               valid_r, valid_s;

  logic [M_WIDTH:0]   t_s;
  logic [M_WIDTH:0]   diff_s;
  logic [M_WIDTH:0]   rem_s;
  logic               ge_s;

  // One restoring step: shift in the next product bit, subtract the modulus if it fits.
  // T stays below 2*M because R < M, so the M_WIDTH+1-bit subtract never overflows.
  always_comb begin
    t_s    = {r_r[M_WIDTH-1:0], p_r[P_WIDTH-1]};
    ge_s   = (t_s >= {1'b0, m_r});
    diff_s = t_s - {1'b0, m_r};
    if (ge_s) begin
      rem_s = diff_s;
    end else begin
      rem_s = t_s;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_s = state_r;
    p_s     = p_r;
    m_s     = m_r;
    r_s     = r_r;
    cnt_s   = cnt_r;
    data_s  = data_r;
    user_s  = user_r;
    valid_s = valid_r;
    case (state_r)
      ST_IDLE: begin
        if (input_tvalid) begin
          p_s     = input_tdata;
          m_s     = modulus_tdata;
          r_s     = {(M_WIDTH+1){1'b0}};
          cnt_s   = {CNT_W{1'b0}};
          state_s = ST_CALC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        // A zero modulus is resolved on the first CALC cycle, giving a one-cycle latency.
        if (m_r == {M_WIDTH{1'b0}}) begin
          data_s  = {M_WIDTH{1'b0}};
          user_s  = 1'b1;
          valid_s = 1'b1;
          state_s = ST_DONE;
        end else begin
          p_s   = {p_r[P_WIDTH-2:0], 1'b0};
          r_s   = rem_s;
          cnt_s = cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            data_s  = rem_s[M_WIDTH-1:0];
            user_s  = 1'b0;
            valid_s = 1'b1;
            state_s = ST_DONE;
          end else begin
            state_s = ST_CALC;
          end
        end
      end
      ST_DONE: begin
        if (output_tready) begin
          valid_s = 1'b0;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        valid_s = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      p_r     <= {P_WIDTH{1'b0}};
      m_r     <= {M_WIDTH{1'b0}};
      r_r     <= {(M_WIDTH+1){1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      data_r  <= {M_WIDTH{1'b0}};
      user_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      p_r     <= p_s;
      m_r     <= m_s;
      r_r     <= r_s;
      cnt_r   <= cnt_s;
      data_r  <= data_s;
      user_r  <= user_s;
      valid_r <= valid_s;
    end
  end

  assign input_tready  = rst & (state_r == ST_IDLE);
  assign output_tdata  = data_r;
  assign output_tuser  = user_r;
  assign output_tvalid = valid_r;

endmodule
